// File: rtl/clk_tick_rx_pkg.sv
// Shared types and defaults for the slow-clock tick receiver.
// FSM encodings and default parameter values.
package clk_tick_rx_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STEP_IDLE  = 2'd1,
    ST_STEP_ARMED = 2'd2
  } state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 26;
  localparam int DEF_TIMEOUT     = 1_000_000;
  localparam int DEF_DEBOUNCE    = 250_000;

endpackage

// File: rtl/clk_tick_rx_debounce.sv
// Push-button synchroniser and debouncer.
// Emits a one-cycle press pulse on an accepted 0->1 level change.
module clk_tick_rx_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 250_000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];
  assign press = press_q;

  // cnt counts consecutive cycles the synced input differs from level
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (btn_s != level_q) begin
      if (cnt_q == DW'(DEBOUNCE - 1)) begin
        level_d = btn_s;
        press_d = btn_s;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

endmodule

// File: rtl/clk_tick_rx.sv
// Slow-clock receiver: synchronises slow_in, emits advance ticks,
// measures the slow period, flags clock loss, supports single-step.
module clk_tick_rx
  import clk_tick_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_in,
  input  logic             enable,
  input  logic             step_mode,
  input  logic             step_btn,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             clk_lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   lost_q, lost_d;
  logic                   armed_q, armed_d;
  state_e                 state_q;
  logic                   tick_q;
  logic                   rise;
  logic                   press;
  logic                   timeout_hit;

  clk_tick_rx_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE)
  ) u_deb (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .btn   (step_btn),
    .press (press)
  );

  assign rise         = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign timeout_hit  = (64'(cnt_q) == 64'(TIMEOUT));
  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign clk_lost     = lost_q;

  // Arming rise only starts a measurement; the following one validates it
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], slow_in};
    dly_d    = sync_q[SYNC_STAGES-1];
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    period_d = period_q;
    valid_d  = valid_q;
    lost_d   = lost_q;
    armed_d  = armed_q;
    if (rise) begin
      period_d = cnt_q;
      cnt_d    = CNT_W'(1);
      valid_d  = armed_q;
      armed_d  = 1'b1;
      lost_d   = 1'b0;
    end else if (timeout_hit) begin
      lost_d  = 1'b1;
      valid_d = 1'b0;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      dly_q    <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
      armed_q  <= armed_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          tick_q <= rise & enable;
          if (step_mode) state_q <= ST_STEP_IDLE;
        end
        ST_STEP_IDLE: begin
          if (!step_mode)  state_q <= ST_RUN;
          else if (press)  state_q <= ST_STEP_ARMED;
        end
        ST_STEP_ARMED: begin
          // a press here is dropped; disabled rises are not consumed
          if (!step_mode) begin
            state_q <= ST_RUN;
          end else if (rise & enable) begin
            tick_q  <= 1'b1;
            state_q <= ST_STEP_IDLE;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_tick_rx.sv
// Directed bench for clk_tick_rx with a tick scoreboard.
// Second instance covers counter saturation below the timeout.
module tb_clk_tick_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_in = 1'b0;
  logic       slow2 = 1'b0;
  logic       enable = 1'b1;
  logic       step_mode = 1'b0;
  logic       btn = 1'b0;
  logic       tick, tick2;
  logic [7:0] period, period2;
  logic       valid, valid2;
  logic       lost, lost2;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int last_rise = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clk_tick_rx #(
    .SYNC_STAGES(2), .CNT_W(8), .TIMEOUT(64), .DEBOUNCE(4)
  ) dut (
    .clk_in(clk), .rst_n(rst_n), .slow_in(slow_in),
    .enable(enable), .step_mode(step_mode), .step_btn(btn),
    .tick(tick), .period(period),
    .period_valid(valid), .clk_lost(lost)
  );

  clk_tick_rx #(
    .SYNC_STAGES(2), .CNT_W(8), .TIMEOUT(300), .DEBOUNCE(4)
  ) dut2 (
    .clk_in(clk), .rst_n(rst_n), .slow_in(slow2),
    .enable(enable), .step_mode(step_mode), .step_btn(btn),
    .tick(tick2), .period(period2),
    .period_valid(valid2), .clk_lost(lost2)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Tick appears three posedges after slow_in is first sampled high
  task automatic slow_period(input int len, input bit exp_tick,
                             input bit which);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (which) slow2 = (i < len / 2);
      else slow_in = (i < len / 2);
      if (i == 0 && !which) begin
        last_rise = cyc + 3;
        if (exp_tick) exp_q.push_back(cyc + 3);
      end
    end
  endtask

  task automatic btn_hold(input logic v, input int n);
    @(negedge clk);
    btn = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic press_btn();
    btn_hold(1'b1, 8);
    btn_hold(1'b0, 8);
  endtask

  always @(negedge clk) begin
    if (rst_n && tick) begin
      if (exp_q.size() == 0) check("tick_unexpected", 32'(tick), 0);
      else check("tick_cycle", cyc, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tick", 32'(tick), 0);
    check("rst_period", 32'(period), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_lost", 32'(lost), 0);
    rst_n = 1'b1;

    // 1: run mode, 20-cycle slow clock
    slow_period(20, 1, 0);
    check("t1_valid_arm", 32'(valid), 0);
    slow_period(20, 1, 0);
    check("t1_period", 32'(period), 20);
    check("t1_valid", 32'(valid), 1);
    slow_period(20, 1, 0);
    check("t1_period3", 32'(period), 20);
    check("t1_lost", 32'(lost), 0);

    // 2: stop slow_in, timeout exactly at cnt==64
    while (cyc < last_rise + 63) @(negedge clk);
    check("t2_lost_pre", 32'(lost), 0);
    check("t2_valid_pre", 32'(valid), 1);
    @(negedge clk);
    check("t2_lost", 32'(lost), 1);
    check("t2_valid_drop", 32'(valid), 0);
    slow_period(20, 1, 0);
    check("t2_lost_clr", 32'(lost), 0);
    check("t2_valid_rearm", 32'(valid), 0);
    slow_period(20, 1, 0);
    check("t2_valid", 32'(valid), 1);
    check("t2_period", 32'(period), 20);
    check("t2_missed", exp_q.size(), 0);

    // 3: single-step with bouncy button
    @(negedge clk);
    step_mode = 1'b1;
    btn_hold(1'b1, 1);
    btn_hold(1'b0, 1);
    btn_hold(1'b1, 1);
    btn_hold(1'b0, 1);
    slow_period(20, 0, 0);
    btn_hold(1'b1, 10);
    btn_hold(1'b0, 10);
    slow_period(20, 1, 0);
    slow_period(20, 0, 0);
    slow_period(20, 0, 0);
    check("t3_missed", exp_q.size(), 0);

    // 4: run with enable low, period keeps measuring
    @(negedge clk);
    step_mode = 1'b0;
    enable = 1'b0;
    slow_period(30, 0, 0);
    slow_period(20, 0, 0);
    check("t4_period30", 32'(period), 30);
    repeat (3) slow_period(20, 0, 0);
    check("t4_period", 32'(period), 20);
    check("t4_valid", 32'(valid), 1);

    // 5: reset while armed and with a half-debounced button
    @(negedge clk);
    enable = 1'b1;
    step_mode = 1'b1;
    press_btn();
    btn_hold(1'b1, 2);
    @(negedge clk);
    btn = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_tick", 32'(tick), 0);
    check("t5_period", 32'(period), 0);
    check("t5_valid", 32'(valid), 0);
    check("t5_lost", 32'(lost), 0);
    check("t5_period2", 32'(period2), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    slow_period(20, 0, 0);
    check("t5_valid_arm", 32'(valid), 0);
    slow_period(20, 0, 0);
    check("t5_valid", 32'(valid), 1);
    check("t5_period20", 32'(period), 20);
    press_btn();
    slow_period(20, 1, 0);
    slow_period(20, 0, 0);
    check("t5_missed", exp_q.size(), 0);

    // 6: period longer than counter range, below timeout
    @(negedge clk);
    step_mode = 1'b0;
    slow_period(280, 0, 1);
    check("t6_lost_a", 32'(lost2), 0);
    slow_period(280, 0, 1);
    check("t6_period", 32'(period2), 255);
    check("t6_valid", 32'(valid2), 1);
    check("t6_lost", 32'(lost2), 0);
    check("t6_dut1_lost", 32'(lost), 1);
    check("t6_missed", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
